// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/compare ops and iterative
// one-bit-per-clock shifts, with a registered result and a one-cycle done pulse.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    localparam int unsigned SHW = 5;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;
    localparam logic [3:0] OP_SRA  = 4'b1100;

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

    state_t           state_q, state_d;
    shkind_t          shk_q, shk_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic [WIDTH-1:0] imm_res;
    logic             imm_legal;
    logic             is_shift;
    shkind_t          req_shk;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shifted;

    assign shamt = SrcB[SHW-1:0];

    // Single-cycle result for every op; shifts with shamt=0 return SrcA.
    always_comb begin
        imm_res   = '0;
        imm_legal = 1'b1;
        is_shift  = 1'b0;
        req_shk   = SH_LL;
        unique case (ALUControl)
            OP_AND:  imm_res = SrcA & SrcB;
            OP_OR:   imm_res = SrcA | SrcB;
            OP_ADD:  imm_res = SrcA + SrcB;
            OP_XOR:  imm_res = SrcA ^ SrcB;
            OP_SUB:  imm_res = SrcA - SrcB;
            OP_SLT:  imm_res = WIDTH'($signed(SrcA) < $signed(SrcB));
            OP_SLTU: imm_res = WIDTH'(SrcA < SrcB);
            OP_SLL: begin imm_res = SrcA; is_shift = 1'b1; req_shk = SH_LL; end
            OP_SRL: begin imm_res = SrcA; is_shift = 1'b1; req_shk = SH_RL; end
            OP_SRA: begin imm_res = SrcA; is_shift = 1'b1; req_shk = SH_RA; end
            default: imm_legal = 1'b0;
        endcase
    end

    // One-bit shift step; the MSB of the working register is the captured sign.
    always_comb begin
        shifted = shreg_q;
        unique case (shk_q)
            SH_LL:   shifted = {shreg_q[WIDTH-2:0], 1'b0};
            SH_RL:   shifted = {1'b0, shreg_q[WIDTH-1:1]};
            SH_RA:   shifted = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
            default: shifted = shreg_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        shk_d     = shk_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        state_d = SHIFT;
                        shk_d   = req_shk;
                        cnt_d   = shamt;
                        shreg_d = SrcA;
                        busy_d  = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                        result_d  = imm_res;
                        zero_d    = (imm_res == '0);
                        illegal_d = ~imm_legal;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    result_d  = shifted;
                    zero_d    = (shifted == '0);
                    illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shk_q     <= SH_LL;
            cnt_q     <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shk_q     <= shk_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: hand-computed vectors, latency/busy profile,
// busy-start rejection, back-to-back issue, mid-shift reset and illegal codes.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        busy;
    logic        done;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ALUResult(ALUResult), .Zero(Zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"},    32'(busy),    32'd0);
        chk({tag, " done"},    32'(done),    32'd0);
        chk({tag, " result"},  ALUResult,    32'd0);
        chk({tag, " zero"},    32'(Zero),    32'd1);
        chk({tag, " illegal"}, 32'(illegal), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge one cycle after done.
    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input logic ill);
        ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ALUControl = 4'($urandom);
        SrcA = $urandom;
        SrcB = $urandom;
        for (int i = 0; i < lat; i++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " early done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        chk({tag, " done"},    32'(done),    32'd1);
        chk({tag, " busy@done"}, 32'(busy),  32'd0);
        chk({tag, " result"},  ALUResult,    exp);
        chk({tag, " zero"},    32'(Zero),    32'(exp == 32'd0));
        chk({tag, " illegal"}, 32'(illegal), 32'(ill));
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " hold"}, ALUResult, exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run("add 5+7",      4'b0010, 32'd5,          32'd7,  32'd12,         0, 1'b0);
        run("sub 3-3",      4'b0110, 32'd3,          32'd3,  32'd0,          0, 1'b0);
        run("add wrap",     4'b0010, 32'hFFFF_FFFF,  32'd1,  32'd0,          0, 1'b0);
        run("and",          4'b0000, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000, 0, 1'b0);
        run("or",           4'b0001, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_FFF0, 0, 1'b0);
        run("xor",          4'b0100, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_0FF0, 0, 1'b0);
        run("sra 4",        4'b1100, 32'h8000_0000,  32'd4,  32'hF800_0000,  4, 1'b0);
        run("srl 4",        4'b1011, 32'h8000_0000,  32'd4,  32'h0800_0000,  4, 1'b0);
        run("slt",          4'b0111, 32'hFFFF_FFFF,  32'd1,  32'd1,          0, 1'b0);
        run("sltu",         4'b1000, 32'hFFFF_FFFF,  32'd1,  32'd0,          0, 1'b0);
        run("sll shamt0",   4'b1010, 32'h1234_5678,  32'd32, 32'h1234_5678,  0, 1'b0);
        run("sll 31",       4'b1010, 32'd1,          32'd31, 32'h8000_0000, 31, 1'b0);
        run("sra 31",       4'b1100, 32'h8000_0000,  32'd31, 32'hFFFF_FFFF, 31, 1'b0);

        // sll by 3 with a competing start held through busy and into the done cycle
        ALUControl = 4'b1010; SrcA = 32'd1; SrcB = 32'd3; start = 1'b1;
        @(negedge clk);
        ALUControl = 4'b0010; SrcA = 32'd100; SrcB = 32'd200;
        for (int i = 0; i < 3; i++) begin
            chk("b2b busy", 32'(busy), 32'd1);
            chk("b2b no extra done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("b2b sll done", 32'(done), 32'd1);
        chk("b2b sll result", ALUResult, 32'd8);
        @(negedge clk);
        start = 1'b0;
        chk("b2b add done", 32'(done), 32'd1);
        chk("b2b add busy", 32'(busy), 32'd0);
        chk("b2b add result", ALUResult, 32'd300);
        @(negedge clk);
        chk("b2b done low", 32'(done), 32'd0);

        // reset in the middle of a 10-bit sra; a start under reset is ignored
        ALUControl = 4'b1100; SrcA = 32'h8000_0000; SrcB = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midshift busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        ALUControl = 4'b0010; SrcA = 32'd1; SrcB = 32'd1; start = 1'b1;
        @(negedge clk);
        chk_reset_vals("midshift reset");
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post-reset no done", 32'(done), 32'd0);
            chk("post-reset idle", 32'(busy), 32'd0);
        end

        run("add again",    4'b0010, 32'd5,  32'd7,  32'd12, 0, 1'b0);
        run("illegal 1111", 4'b1111, 32'd5,  32'd7,  32'd0,  0, 1'b1);
        run("illegal 0011", 4'b0011, 32'd9,  32'd9,  32'd0,  0, 1'b1);
        run("legal clears", 4'b0110, 32'd10, 32'd3,  32'd7,  0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
